bytes_to_bits_stream: RTL and testbench
=======================================

BYTES_TO_BITS_STREAM -- requirements
Module: bytes_to_bits_stream

Interface
REQ-001 SHALL have parameter BIT_LENGTH, default 2048, output frame width in bits; a multiple of 8 and at least 16.
REQ-002 SHALL have parameter BYTE_LENGTH, default BIT_LENGTH/8, number of bytes per frame.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous frame abort.
REQ-006 SHALL have port in_valid  input  1  in_byte carries a valid byte.
REQ-007 SHALL have port in_ready  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port in_byte  input  8  next byte of the frame, byte 0 first.
REQ-009 SHALL have port out_valid  output  1  bit_array holds a complete frame.
REQ-010 SHALL have port out_ready  input  1  consumer takes the frame this cycle.
REQ-011 SHALL have port bit_array  output  BIT_LENGTH  assembled frame.
REQ-012 SHALL have port byte_count  output  $clog2(BYTE_LENGTH+1)  bytes accepted in the current frame.

Function
REQ-013 SHALL implement two states: FILL (in_ready=1, out_valid=0) and FULL (in_ready=0, out_valid=1).
REQ-014 SHALL accept a byte only when in_valid and in_ready are both 1 in the same cycle.
REQ-015 SHALL, on accepting byte i, set bit_array[i*8+k] = in_byte[7-k] for k=0..7, with i = byte_count; this is the exact inverse of the team's bits_to_bytes packing.
REQ-016 SHALL leave all other bit_array bits unchanged on an accept.
REQ-017 SHALL increment byte_count by 1 on each accept in FILL while byte_count < BYTE_LENGTH-1.
REQ-018 SHALL, on accepting byte BYTE_LENGTH-1, move to FULL and set byte_count=BYTE_LENGTH, with out_valid=1 on the next cycle.
REQ-019 SHALL hold bit_array and out_valid stable in FULL until out_ready=1.
REQ-020 SHALL, in FULL with out_ready=1, return to FILL with byte_count=0 on the next cycle, leaving bit_array contents stale (not cleared).
REQ-021 SHALL, on flush=1 in either state, go to FILL with byte_count=0 on the next cycle; flush overrides a simultaneous accept or out_ready, and bit_array is not modified that cycle.
REQ-022 SHALL ignore in_byte and in_valid whenever in_ready=0.
REQ-023 SHALL drive in_ready and out_valid combinationally from state only.

Reset
REQ-024 SHALL, while rst=1, immediately force state FILL, byte_count=0, bit_array=0, out_valid=0, in_ready=1.
REQ-025 SHALL discard any partially assembled frame on rst mid-frame, with no out_valid pulse.
REQ-026 SHALL resume accepting on the first rising clk edge after rst deasserts.

Configuration
REQ-027 SHALL support macro BYTES_TO_BITS_PASSTHRU_EN.
REQ-028 SHALL, with BYTES_TO_BITS_PASSTHRU_EN defined, assert in_ready in FULL when out_ready=1; an accept in that cycle writes byte 0 of the next frame, sets byte_count=1 and enters FILL with zero bubble cycles.
REQ-029 SHALL, without BYTES_TO_BITS_PASSTHRU_EN, keep in_ready=0 throughout FULL, giving one bubble cycle between frames.

Verification (BIT_LENGTH=16 unless stated)
REQ-030 SHALL cover: bytes 0x01 then 0x80 with in_valid held -> out_valid=1 one cycle after the second accept, with bit_array=0x0180 and byte_count=2.
REQ-031 SHALL cover: in FULL, out_ready=0 for 5 cycles with in_valid=1 and in_byte toggling -> bit_array, out_valid=1 and in_ready=0 stay constant.
REQ-032 SHALL cover: flush asserted together with the second accept -> byte_count=0, no out_valid, then bytes 0xFF, 0x00 -> bit_array=0x00FF.
REQ-033 SHALL cover: rst pulsed asynchronously between clock edges after 1 byte -> bit_array=0 and byte_count=0 immediately, and in_ready=1.
REQ-034 SHALL cover: with BYTES_TO_BITS_PASSTHRU_EN, back-to-back frames 0xA5,0x3C then 0x12,0x34 with out_ready=1 -> outputs 0x3CA5 then 0x2C48, with no idle cycle; without the macro, one idle cycle appears.
REQ-035 SHALL cover: default BIT_LENGTH=2048 with 256 random bytes -> feeding bit_array through bits_to_bytes reproduces the input bytes exactly.

Source files
------------

// File: rtl/bytes_to_bits_stream.sv
// ---------------------------------------------------------------------------
// bytes_to_bits_stream
//
// Collects a frame of BYTE_LENGTH bytes from a valid/ready byte stream and
// presents it as one BIT_LENGTH-wide word. Within each byte the bit order is
// mirrored: byte i, bit (7-k) lands on bit_array[i*8+k]. This is the inverse
// of the bits_to_bytes packer used elsewhere in the lab codebase.
//
// Parameters
//   BIT_LENGTH   frame width in bits (multiple of 8, at least 16)
//   BYTE_LENGTH  bytes per frame (BIT_LENGTH/8)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-high reset
//   flush       synchronous abort of the current frame
//   in_valid    in_byte carries a byte
//   in_ready    block can take a byte this cycle
//   in_byte     next byte of the frame, byte 0 first
//   out_valid   bit_array holds a complete frame
//   out_ready   consumer takes the frame this cycle
//   bit_array   assembled frame
//   byte_count  bytes accepted in the current frame
//
// Optional feature (macro BYTES_TO_BITS_PASSTHRU_EN)
//   When defined, a byte offered in the same cycle that a full frame is
//   handed off becomes byte 0 of the next frame, so frames can stream with
//   no bubble cycle. When undefined, in_ready stays low for the whole FULL
//   state and one idle cycle separates frames.
// ---------------------------------------------------------------------------
module bytes_to_bits_stream #(
    parameter int BIT_LENGTH  = 2048,
    parameter int BYTE_LENGTH = BIT_LENGTH / 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [7:0]                         in_byte,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [BIT_LENGTH-1:0]              bit_array,
    output logic [$clog2(BYTE_LENGTH+1)-1:0]   byte_count
);

    localparam int CW = $clog2(BYTE_LENGTH + 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count_next;
    logic          write_en;
    logic [CW-1:0] write_idx;
    logic [7:0]    byte_rev;
    logic          accept;

    // Mirror the incoming byte so that its MSB ends up on the lowest bit of
    // its slot in bit_array.
    always_comb begin
        byte_rev = '0;
        for (int k = 0; k < 8; k++) begin
            byte_rev[k] = in_byte[7-k];
        end
    end

    // Handshake outputs come from the state register; in pass-through builds
    // the consumer taking the frame also opens the input for byte 0 of the
    // next frame in the same cycle.
    always_comb begin
        in_ready  = (state == FILL);
        out_valid = (state == FULL);
`ifdef BYTES_TO_BITS_PASSTHRU_EN
        if (state == FULL && out_ready) begin
            in_ready = 1'b1;
        end
`endif
    end

    assign accept = in_valid && in_ready;

    // Next-state, next-count and byte write decision. Flush wins over any
    // simultaneous accept or hand-off and leaves bit_array untouched.
    always_comb begin
        state_next = state;
        count_next = byte_count;
        write_en   = 1'b0;
        write_idx  = byte_count;
        if (flush) begin
            state_next = FILL;
            count_next = '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        write_en = 1'b1;
                        if (byte_count == CW'(BYTE_LENGTH - 1)) begin
                            state_next = FULL;
                            count_next = CW'(BYTE_LENGTH);
                        end else begin
                            count_next = byte_count + CW'(1);
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_next = FILL;
                        count_next = '0;
`ifdef BYTES_TO_BITS_PASSTHRU_EN
                        if (accept) begin
                            write_en   = 1'b1;
                            write_idx  = '0;
                            count_next = CW'(1);
                        end
`endif
                    end
                end
                default: begin
                    state_next = FILL;
                    count_next = '0;
                end
            endcase
        end
    end

    // State and byte counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            byte_count <= '0;
        end else begin
            state      <= state_next;
            byte_count <= count_next;
        end
    end

    // Frame storage: only the addressed byte slot is written on an accept;
    // everything else, including a handed-off frame, is left as it was.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_array <= '0;
        end else if (write_en) begin
            for (int i = 0; i < BYTE_LENGTH; i++) begin
                if (write_idx == CW'(i)) begin
                    bit_array[i*8 +: 8] <= byte_rev;
                end
            end
        end
    end

endmodule

// File: tb/tb_bytes_to_bits_stream.sv
// ---------------------------------------------------------------------------
// tb_bytes_to_bits_stream
//
// Self-checking bench for bytes_to_bits_stream. A 16-bit instance is driven
// with directed and random traffic and compared against a byte-level model;
// a default 2048-bit instance is filled with 256 random bytes and its frame
// is unpacked again with a bits_to_bytes style routine.
// ---------------------------------------------------------------------------
module tb_bytes_to_bits_stream;

`ifdef BYTES_TO_BITS_PASSTHRU_EN
    localparam bit PASSTHRU = 1'b1;
`else
    localparam bit PASSTHRU = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] bit_array;
    logic [1:0]  byte_count;

    logic          big_flush;
    logic          big_in_valid;
    logic          big_in_ready;
    logic [7:0]    big_in_byte;
    logic          big_out_valid;
    logic          big_out_ready;
    logic [2047:0] big_bit_array;
    logic [8:0]    big_byte_count;

    int checks = 0;
    int errors = 0;

    // Reference model: frame contents, number of bytes held, frame complete.
    logic [15:0] m_frame;
    int          m_count;
    bit          m_full;

    always #5 clk = ~clk;

    bytes_to_bits_stream #(.BIT_LENGTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_byte    (in_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bit_array  (bit_array),
        .byte_count (byte_count)
    );

    bytes_to_bits_stream big_dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (big_flush),
        .in_valid   (big_in_valid),
        .in_ready   (big_in_ready),
        .in_byte    (big_in_byte),
        .out_valid  (big_out_valid),
        .out_ready  (big_out_ready),
        .bit_array  (big_bit_array),
        .byte_count (big_byte_count)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_frame = '0;
        m_count = 0;
        m_full  = 1'b0;
    endtask

    // Byte b goes into frame slot idx with its bit order mirrored.
    task automatic modelPlace(input int idx, input logic [7:0] b);
        for (int k = 0; k < 8; k++) begin
            m_frame[idx*8 + k] = b[7-k];
        end
    endtask

    function automatic bit modelReady();
        return !m_full || (PASSTHRU && out_ready);
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        bit rdy;
        rdy = modelReady();
        if (flush) begin
            m_full  = 1'b0;
            m_count = 0;
        end else if (!m_full) begin
            if (in_valid) begin
                modelPlace(m_count, in_byte);
                m_count++;
                if (m_count == 2) m_full = 1'b1;
            end
        end else if (out_ready) begin
            m_full  = 1'b0;
            m_count = 0;
            if (in_valid && rdy) begin
                modelPlace(0, in_byte);
                m_count = 1;
            end
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".out_valid"},  32'(out_valid),  32'(m_full));
        checkOutput({tag, ".in_ready"},   32'(in_ready),   32'(modelReady()));
        checkOutput({tag, ".bit_array"},  32'(bit_array),  32'(m_frame));
        checkOutput({tag, ".byte_count"}, 32'(byte_count), 32'(m_count));
    endtask

    // Drive one cycle of inputs, step the model, then check after the edge.
    task automatic applyStimulus(input logic v, input logic [7:0] b,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_byte   = b;
        out_ready = ordy;
        flush     = fl;
        modelStep();
        @(posedge clk);
        #1;
        checkModel("step");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] sent [256];
        logic [7:0] rebuilt;
        logic [7:0] q [$];
        int         frames_seen;
        int         c1;
        int         c2;
        bit         acc;

        rst           = 1'b1;
        flush         = 1'b0;
        in_valid      = 1'b0;
        in_byte       = 8'h00;
        out_ready     = 1'b0;
        big_flush     = 1'b0;
        big_in_valid  = 1'b0;
        big_in_byte   = 8'h00;
        big_out_ready = 1'b0;
        modelReset();

        // Reset state while rst is held.
        #12;
        checkOutput("reset.in_ready",   32'(in_ready),   32'd1);
        checkOutput("reset.out_valid",  32'(out_valid),  32'd0);
        checkOutput("reset.bit_array",  32'(bit_array),  32'd0);
        checkOutput("reset.byte_count", 32'(byte_count), 32'd0);
        #1 rst = 1'b0;

        // Two bytes complete a frame; out_valid follows the second accept.
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h80, 1'b0, 1'b0);
        checkOutput("frame1.out_valid",  32'(out_valid),  32'd1);
        checkOutput("frame1.bit_array",  32'(bit_array),  32'h0180);
        checkOutput("frame1.byte_count", 32'(byte_count), 32'd2);

        // Consumer stalls: everything stays frozen despite input activity.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, (i % 2 == 1) ? 8'hFF : 8'h00, 1'b0, 1'b0);
            checkOutput("hold.bit_array", 32'(bit_array), 32'h0180);
            checkOutput("hold.out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold.in_ready",  32'(in_ready),  32'd0);
        end

        // Hand-off leaves stale data and restarts the count.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("handoff.byte_count", 32'(byte_count), 32'd0);
        checkOutput("handoff.bit_array",  32'(bit_array),  32'h0180);

        // Flush on the second accept aborts the frame.
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b1);
        checkOutput("flush.byte_count", 32'(byte_count), 32'd0);
        checkOutput("flush.out_valid",  32'(out_valid),  32'd0);
        checkOutput("flush.bit_array",  32'(bit_array),  32'h0188);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("postflush.bit_array", 32'(bit_array), 32'h00FF);
        checkOutput("postflush.out_valid", 32'(out_valid), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset between edges after one byte.
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        checkOutput("prerst.bit_array", 32'(bit_array), 32'h005A);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncrst.bit_array",  32'(bit_array),  32'd0);
        checkOutput("asyncrst.byte_count", 32'(byte_count), 32'd0);
        checkOutput("asyncrst.in_ready",   32'(in_ready),   32'd1);
        checkOutput("asyncrst.out_valid",  32'(out_valid),  32'd0);
        modelReset();
        #1 rst = 1'b0;
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
        checkOutput("resume.byte_count", 32'(byte_count), 32'd1);

        // Flush the partial frame, then stream two frames back to back.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        q = '{8'hA5, 8'h3C, 8'h12, 8'h34};
        frames_seen = 0;
        c1 = 0;
        c2 = 0;
        for (int cyc = 1; cyc <= 20 && frames_seen < 2; cyc++) begin
            out_ready = 1'b1;
            acc = (q.size() > 0) && modelReady();
            applyStimulus(q.size() > 0, (q.size() > 0) ? q[0] : 8'h00, 1'b1, 1'b0);
            if (acc) void'(q.pop_front());
            if (out_valid) begin
                frames_seen++;
                if (frames_seen == 1) begin
                    c1 = cyc;
                    checkOutput("stream.frame1", 32'(bit_array), 32'h3CA5);
                end else begin
                    c2 = cyc;
                    checkOutput("stream.frame2", 32'(bit_array), 32'h2C48);
                end
            end
        end
        checkOutput("stream.frames_seen", 32'(frames_seen), 32'd2);
        checkOutput("stream.gap", 32'(c2 - c1), PASSTHRU ? 32'd2 : 32'd3);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                          1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
        end

        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Full-size frame: 256 random bytes, then unpack and compare.
        for (int i = 0; i < 256; i++) begin
            sent[i]      = 8'($urandom);
            big_in_valid = 1'b1;
            big_in_byte  = sent[i];
            @(posedge clk);
            #1;
        end
        big_in_valid = 1'b0;
        checkOutput("big.out_valid",  32'(big_out_valid),  32'd1);
        checkOutput("big.in_ready",   32'(big_in_ready),   32'd0);
        checkOutput("big.byte_count", 32'(big_byte_count), 32'd256);
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 8; j++) begin
                rebuilt[j] = big_bit_array[i*8 + 7 - j];
            end
            checkOutput($sformatf("big.byte%0d", i), 32'(rebuilt), 32'(sent[i]));
        end
        big_out_ready = 1'b1;
        @(posedge clk);
        #1;
        big_out_ready = 1'b0;
        checkOutput("big.drain_count", 32'(big_byte_count), 32'd0);
        checkOutput("big.drain_valid", 32'(big_out_valid),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
